dm_responder: RTL and testbench

//  Data-memory responder answering the CPU's load/store requests.
//  - Sits between the CPU datapath (Addr/DataIn/WriteEnable/ReadEnable) and on-chip word RAM.
//  - Replaces a zero-latency DM: inserts configurable wait states, acknowledges with a

---
 rtl/dm_responder.sv | 151 +++++++++++++++
 tb/tb_dm_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder: wait states, four-phase Ack, illegal-access Error
// Optional macro DM_ACCESS_COUNT_EN adds saturating RdCount/WrCount legal-access counters.
module dm_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  input  logic        WriteEnable,
  input  logic        ReadEnable,
  output logic [31:0] DataOut,
  output logic        Ack,
  output logic        Busy,
  output logic        Error
`ifdef DM_ACCESS_COUNT_EN
  ,
  output logic [15:0] RdCount,
  output logic [15:0] WrCount
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [31:0] dout_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic [31:0] sel_addr;
  logic [31:0] sel_data;
  logic        sel_wr;
  logic        sel_rd;
  logic        illegal;
  logic        commit;
  logic [AW-1:0] word;

  // With zero wait states the commit edge is the capture edge, so the live inputs are used.
  always_comb begin
    sel_addr = addr_q;
    sel_data = data_q;
    sel_wr   = wr_q;
    sel_rd   = rd_q;
    if (state_q == S_IDLE) begin
      sel_addr = Addr;
      sel_data = DataIn;
      sel_wr   = WriteEnable;
      sel_rd   = ReadEnable;
    end
  end

  assign illegal = (sel_addr[1:0] != 2'b00) ||
                   ({2'b00, sel_addr[31:2]} >= 32'(DEPTH)) ||
                   (sel_wr && sel_rd);
  assign word    = sel_addr[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: begin
        if (WriteEnable || ReadEnable) begin
          addr_d  = Addr;
          data_d  = DataIn;
          wr_d    = WriteEnable;
          rd_d    = ReadEnable;
          cnt_d   = 4'd0;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WS_LAST) state_d = S_ACK;
      end
      S_ACK: begin
        if (!WriteEnable && !ReadEnable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign commit = !RESET && (state_q != S_ACK) && (state_d == S_ACK);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      dout_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (commit) begin
        err_q <= illegal;
        if (sel_rd && !illegal) dout_q <= mem[word];
      end else if (state_d != S_ACK) begin
        err_q <= 1'b0;
      end
    end
  end

  // RAM has no reset so contents survive RESET.
  always_ff @(posedge CLOCK) begin
    if (commit && sel_wr && !illegal) mem[word] <= sel_data;
  end

  assign DataOut = dout_q;
  assign Ack     = (state_q == S_ACK);
  assign Busy    = (state_q != S_IDLE);
  assign Error   = err_q;

`ifdef DM_ACCESS_COUNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else if (commit && !illegal) begin
      if (sel_rd && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (sel_wr && (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign RdCount = rd_cnt_q;
  assign WrCount = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed bench: instance 0 has WAIT_STATES=0, instance 1 has WAIT_STATES=2
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst_s  [2];
  logic [31:0] addr_s [2];
  logic [31:0] din_s  [2];
  logic        we_s   [2];
  logic        re_s   [2];
  logic [31:0] dout_s [2];
  logic        ack_s  [2];
  logic        busy_s [2];
  logic        err_s  [2];
`ifdef DM_ACCESS_COUNT_EN
  logic [15:0] rdc_s  [2];
  logic [15:0] wrc_s  [2];
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .CLOCK(clk), .RESET(rst_s[0]), .Addr(addr_s[0]), .DataIn(din_s[0]),
    .WriteEnable(we_s[0]), .ReadEnable(re_s[0]), .DataOut(dout_s[0]),
    .Ack(ack_s[0]), .Busy(busy_s[0]), .Error(err_s[0])
`ifdef DM_ACCESS_COUNT_EN
    , .RdCount(rdc_s[0]), .WrCount(wrc_s[0])
`endif
  );

  dm_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut1 (
    .CLOCK(clk), .RESET(rst_s[1]), .Addr(addr_s[1]), .DataIn(din_s[1]),
    .WriteEnable(we_s[1]), .ReadEnable(re_s[1]), .DataOut(dout_s[1]),
    .Ack(ack_s[1]), .Busy(busy_s[1]), .Error(err_s[1])
`ifdef DM_ACCESS_COUNT_EN
    , .RdCount(rdc_s[1]), .WrCount(wrc_s[1])
`endif
  );

  // lat = number of falling edges after the capture edge until Ack is seen; -1 on timeout.
  task automatic do_access(input int i, input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] q, output logic e,
                           output int lat);
    @(negedge clk);
    we_s[i] = w; re_s[i] = r; addr_s[i] = a; din_s[i] = d;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack_s[i]) begin
        lat = n;
        break;
      end
      addr_s[i] = ~a;
      din_s[i]  = ~d;
    end
    q = dout_s[i];
    e = err_s[i];
    we_s[i] = 1'b0; re_s[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; we_s[i] = 1'b0; re_s[i] = 1'b0; addr_s[i] = 32'd0; din_s[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ack_s[i], busy_s[i], err_s[i]} !== 3'b000 || dout_s[i] !== 32'd0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: ack/busy/err=%b%b%b dout=%h, required 000 and 0",
                 i, ack_s[i], busy_s[i], err_s[i], dout_s[i]);
      end
`ifdef DM_ACCESS_COUNT_EN
      checks++;
      if (rdc_s[i] !== 16'd0 || wrc_s[i] !== 16'd0) begin
        fails++;
        $display("FAIL reset_counts[%0d]: rd=%0d wr=%0d, required 0 0", i, rdc_s[i], wrc_s[i]);
      end
`endif
      rst_s[i] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] q; logic e; int lat;
    do_access(1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, q, e, lat);
    checks++;
    if (lat !== 3 || e !== 1'b0) begin
      fails++; $display("FAIL wr_0x10: lat=%0d err=%b, required lat=3 err=0", lat, e);
    end
    do_access(1, 1'b0, 1'b1, 32'h10, 32'h0, q, e, lat);
    checks++;
    if (lat !== 3 || e !== 1'b0 || q !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd_0x10: lat=%0d err=%b data=%h, required 3 0 deadbeef", lat, e, q);
    end
    checks++;
    if (busy_s[1] !== 1'b0 || ack_s[1] !== 1'b0) begin
      fails++; $display("FAIL idle_after_rd: busy=%b ack=%b, required 0 0", busy_s[1], ack_s[1]);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] q; logic e; int lat;
    do_access(1, 1'b0, 1'b1, 32'h12, 32'h0, q, e, lat);
    checks++;
    if (lat !== 3 || e !== 1'b1 || q !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd_misaligned: lat=%0d err=%b data=%h, required 3 1 deadbeef", lat, e, q);
    end
    do_access(1, 1'b1, 1'b0, 32'h11, 32'h99999999, q, e, lat);
    checks++;
    if (e !== 1'b1) begin
      fails++; $display("FAIL wr_misaligned: err=%b, required 1", e);
    end
    do_access(1, 1'b0, 1'b1, 32'h10, 32'h0, q, e, lat);
    checks++;
    if (e !== 1'b0 || q !== 32'hDEADBEEF) begin
      fails++; $display("FAIL ram4_intact: err=%b data=%h, required 0 deadbeef", e, q);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] q; logic e; int lat;
    do_access(1, 1'b1, 1'b0, 32'h0, 32'h0A0A0A0A, q, e, lat);
    do_access(1, 1'b1, 1'b0, 32'h3FC, 32'hCAFEF00D, q, e, lat);
    checks++;
    if (e !== 1'b0) begin
      fails++; $display("FAIL wr_last_word: err=%b, required 0", e);
    end
    do_access(1, 1'b1, 1'b0, 32'h400, 32'h11111111, q, e, lat);
    checks++;
    if (e !== 1'b1) begin
      fails++; $display("FAIL wr_0x400: err=%b, required 1", e);
    end
    do_access(1, 1'b1, 1'b1, 32'h10, 32'h55555555, q, e, lat);
    checks++;
    if (e !== 1'b1) begin
      fails++; $display("FAIL wr_rd_both: err=%b, required 1", e);
    end
    do_access(1, 1'b0, 1'b1, 32'h0, 32'h0, q, e, lat);
    checks++;
    if (e !== 1'b0 || q !== 32'h0A0A0A0A) begin
      fails++; $display("FAIL ram0_intact: err=%b data=%h, required 0 0a0a0a0a", e, q);
    end
    do_access(1, 1'b0, 1'b1, 32'h3FC, 32'h0, q, e, lat);
    checks++;
    if (e !== 1'b0 || q !== 32'hCAFEF00D) begin
      fails++; $display("FAIL rd_last_word: err=%b data=%h, required 0 cafef00d", e, q);
    end
    do_access(1, 1'b0, 1'b1, 32'h10, 32'h0, q, e, lat);
    checks++;
    if (q !== 32'hDEADBEEF) begin
      fails++; $display("FAIL ram4_after_both: data=%h, required deadbeef", q);
    end
  endtask

  task automatic test_hold_ack();
    int lat;
    int bad;
    @(negedge clk);
    re_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h3FC;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack_s[1]) begin lat = n; break; end
    end
    checks++;
    if (lat !== 3) begin
      fails++; $display("FAIL hold_first_ack: lat=%0d, required 3", lat);
    end
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (ack_s[1] !== 1'b1 || busy_s[1] !== 1'b1 || dout_s[1] !== 32'hCAFEF00D) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++; $display("FAIL hold_ack: %0d cycles lost Ack/Busy/data, required 0", bad);
    end
    re_s[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_s[1] !== 1'b0 || busy_s[1] !== 1'b0 || err_s[1] !== 1'b0) begin
      fails++; $display("FAIL hold_release: ack=%b busy=%b err=%b, required 0 0 0",
                        ack_s[1], busy_s[1], err_s[1]);
    end
    @(negedge clk);
    checks++;
    if (busy_s[1] !== 1'b0) begin
      fails++; $display("FAIL hold_no_second: busy=%b, required 0", busy_s[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q; logic e; int lat;
    do_access(1, 1'b1, 1'b0, 32'h20, 32'hAAAA5555, q, e, lat);
    @(negedge clk);
    we_s[1] = 1'b1; addr_s[1] = 32'h20; din_s[1] = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_s[1] !== 1'b1 || ack_s[1] !== 1'b0) begin
      fails++; $display("FAIL mid_in_wait: busy=%b ack=%b, required 1 0", busy_s[1], ack_s[1]);
    end
    rst_s[1] = 1'b1; we_s[1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack_s[1], busy_s[1], err_s[1]} !== 3'b000 || dout_s[1] !== 32'd0) begin
      fails++; $display("FAIL mid_reset: ack/busy/err=%b%b%b dout=%h, required 000 0",
                        ack_s[1], busy_s[1], err_s[1], dout_s[1]);
    end
    rst_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    do_access(1, 1'b0, 1'b1, 32'h20, 32'h0, q, e, lat);
    checks++;
    if (q !== 32'hAAAA5555 || e !== 1'b0) begin
      fails++; $display("FAIL mid_ram: data=%h err=%b, required aaaa5555 0", q, e);
    end
  endtask

  task automatic test_counts();
    logic [31:0] q; logic e; int lat;
    int lat_bad;
    lat_bad = 0;
    for (int k = 0; k < 3; k++) begin
      do_access(0, 1'b1, 1'b0, 32'(k * 4), 32'h100 + 32'(k), q, e, lat);
      if (lat != 1 || e !== 1'b0) lat_bad++;
    end
    do_access(0, 1'b0, 1'b1, 32'h4, 32'h0, q, e, lat);
    if (lat != 1) lat_bad++;
    checks++;
    if (q !== 32'h101 || e !== 1'b0) begin
      fails++; $display("FAIL ws0_rd_0x4: data=%h err=%b, required 00000101 0", q, e);
    end
    do_access(0, 1'b0, 1'b1, 32'h8, 32'h0, q, e, lat);
    if (lat != 1) lat_bad++;
    checks++;
    if (q !== 32'h102 || e !== 1'b0) begin
      fails++; $display("FAIL ws0_rd_0x8: data=%h err=%b, required 00000102 0", q, e);
    end
    do_access(0, 1'b0, 1'b1, 32'h6, 32'h0, q, e, lat);
    if (lat != 1) lat_bad++;
    checks++;
    if (e !== 1'b1 || q !== 32'h102) begin
      fails++; $display("FAIL ws0_misaligned: err=%b data=%h, required 1 00000102", e, q);
    end
    checks++;
    if (lat_bad != 0) begin
      fails++; $display("FAIL ws0_latency: %0d accesses not acked 1 cycle after capture, required 0", lat_bad);
    end
`ifdef DM_ACCESS_COUNT_EN
    checks++;
    if (wrc_s[0] !== 16'd3 || rdc_s[0] !== 16'd2) begin
      fails++; $display("FAIL ws0_counts: wr=%0d rd=%0d, required 3 2", wrc_s[0], rdc_s[0]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_hold_ack();
    test_reset_mid();
    test_counts();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
